// File: rtl/pipeline_pkg.sv
// Shared helpers for credit-tracked pipeline blocks.
// Counter widths are sized to hold 0..depth inclusive.
package pipeline_pkg;

  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline.sv
// Fixed-latency, non-stallable delay line used as the upstream datapath.
// Each issued item emerges exactly STAGES cycles after it is captured.
module pipeline #(
  parameter int STAGES     = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [STAGES-1:0]     r_valid;
  logic [DATA_WIDTH-1:0] r_data [STAGES];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++)
        r_data[i] <= '0;
    end else begin
      r_valid <= {r_valid[STAGES-2:0], valid_in};
      r_data[0] <= data_in;
      for (int i = 1; i < STAGES; i++)
        r_data[i] <= r_data[i-1];
    end
  end

  assign valid_out = r_valid[STAGES-1];
  assign data_out  = r_data[STAGES-1];

endmodule

// File: rtl/pipeline_return_buffer_mem.sv
// DEPTH x DATA_WIDTH register array: one write port, one async read port.
// Contents are deliberately left unreset.
module ring_buffer_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk_in,
  input  logic                     we_in,
  input  logic [$clog2(DEPTH)-1:0] waddr_in,
  input  logic [DATA_WIDTH-1:0]    wdata_in,
  input  logic [$clog2(DEPTH)-1:0] raddr_in,
  output logic [DATA_WIDTH-1:0]    rdata_out
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we_in)
      r_mem[waddr_in] <= wdata_in;
  end

  assign rdata_out = r_mem[raddr_in];

endmodule

// File: rtl/pipeline_return_buffer.sv
// Credit-tracked landing buffer for a fixed-latency pipeline output.
// Credits = free slots not already claimed by in-flight items.
module pipeline_return_buffer
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       issue_valid_in,
  output logic                       issue_ready_out,
  input  logic                       ret_valid_in,
  input  logic [DATA_WIDTH-1:0]      ret_data_in,
  output logic                       out_valid_out,
  input  logic                       out_ready_in,
  output logic [DATA_WIDTH-1:0]      out_data_out,
  output logic [CNT_W(DEPTH)-1:0]    count_out,
  output logic [CNT_W(DEPTH)-1:0]    inflight_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = CNT_W(DEPTH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic          r_overflow;

  logic [CW:0]   w_used;
  logic          w_full;
  logic          w_issue;
  logic          w_pop;
  logic          w_ret_ok;
  logic          w_drop;

  assign w_used  = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_full  = (r_count == CW'(DEPTH));

  assign issue_ready_out = (w_used < (CW+1)'(DEPTH));
  assign out_valid_out   = (r_count != '0);

  assign w_issue = issue_valid_in && issue_ready_out;
  assign w_pop   = out_valid_out && out_ready_in;

  // A return is only legal against an outstanding credit and a free slot.
  assign w_ret_ok = ret_valid_in && (r_inflight != '0)
                 && (!w_full || w_pop);
  assign w_drop   = ret_valid_in && !w_ret_ok;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + PW'(w_ret_ok);
      r_rptr     <= r_rptr + PW'(w_pop);
      r_count    <= r_count + CW'(w_ret_ok) - CW'(w_pop);
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_ret_ok);
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  ring_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_in    (clk_in),
    .we_in     (w_ret_ok),
    .waddr_in  (r_wptr),
    .wdata_in  (ret_data_in),
    .raddr_in  (r_rptr),
    .rdata_out (out_data_out)
  );

  assign count_out    = r_count;
  assign inflight_out = r_inflight;
  assign overflow_out = r_overflow;

endmodule
